// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one ripple-carry adder among NUM_REQ requesters.
// One operation in flight: IDLE (grant/capture) -> EXEC (add) -> RESP (hold until accepted).

module adder_rr_scheduler_rca #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_y,
    output logic             o_cout
);
    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        assign o_y[g]     = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_c[WIDTH];
endmodule

module adder_rr_scheduler #(
    parameter int WORD_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [IDX_W-1:0]              rsp_id,
    output logic [WORD_WIDTH-1:0]         rsp_y,
    output logic                          rsp_cout,
    output logic                          busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [WORD_WIDTH-1:0] r_op_a;
    logic [WORD_WIDTH-1:0] r_op_b;
    logic [IDX_W-1:0]      r_op_id;
    logic [WORD_WIDTH-1:0] r_res_y;
    logic                  r_res_cout;
    logic [IDX_W-1:0]      r_rsp_id;
    logic [IDX_W-1:0]      r_rr_ptr;

    logic                  w_found;
    logic [IDX_W-1:0]      w_grant;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_ptr_next;
    logic [WORD_WIDTH-1:0] w_sel_a;
    logic [WORD_WIDTH-1:0] w_sel_b;
    logic [WORD_WIDTH-1:0] w_sum;
    logic                  w_cout;

    // First valid requester at or after r_rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = IDX_W'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == w_grant) begin
                w_sel_a = req_a[k*WORD_WIDTH +: WORD_WIDTH];
                w_sel_b = req_b[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_grant == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

    adder_rr_scheduler_rca #(
        .WIDTH(WORD_WIDTH)
    ) u_adder (
        .i_a   (r_op_a),
        .i_b   (r_op_b),
        .i_cin (1'b0),
        .o_y   (w_sum),
        .o_cout(w_cout)
    );

    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_state       = S_EXEC;
                    req_ready[w_grant] = ~reset;
                end
            end
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_id    <= '0;
            r_res_y    <= '0;
            r_res_cout <= 1'b0;
            r_rsp_id   <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_op_id  <= w_grant;
                        r_rr_ptr <= w_ptr_next;
                    end
                end
                // Response id gets its own register so rsp_id holds through the next EXEC.
                S_EXEC: begin
                    r_res_y    <= w_sum;
                    r_res_cout <= w_cout;
                    r_rsp_id   <= r_op_id;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_y     = r_res_y;
    assign rsp_cout  = r_res_cout;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed table plus hand-written sequences and a random soak for adder_rr_scheduler.

module tb_adder_rr_scheduler;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_y;
    logic           rsp_cout;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    adder_rr_scheduler #(
        .WORD_WIDTH(W),
        .NUM_REQ   (N),
        .IDX_W     (IW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_y    (rsp_y),
        .rsp_cout (rsp_cout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    typedef struct {
        logic [N-1:0] valid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           exp_id;
        logic [W-1:0] exp_y;
        logic         exp_cout;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Entered in IDLE just after a rising edge; returns in IDLE after the handshake.
    task automatic run_vec(input string nm, input vec_t v);
        for (int i = 0; i < N; i++) set_lane(i, v.a, v.b);
        req_valid = v.valid;
        rsp_ready = 1'b0;
        #1;
        chk({nm, " req_ready"}, 64'(req_ready), 64'(onehot(v.exp_id)));
        tick;
        req_valid = '0;
        #1;
        chk({nm, " exec busy"}, 64'(busy), 64'd1);
        chk({nm, " exec rsp_valid"}, 64'(rsp_valid), 64'd0);
        tick;
        chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({nm, " rsp_y"}, 64'(rsp_y), 64'(v.exp_y));
        chk({nm, " rsp_cout"}, 64'(rsp_cout), 64'(v.exp_cout));
        chk({nm, " rsp_id"}, 64'(rsp_id), 64'(v.exp_id));
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        #1;
        chk({nm, " back to idle"}, 64'(busy), 64'd0);
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        #3;
        @(negedge clk);
        reset = 1'b0;
        tick;
    endtask

    vec_t          vecs[7];
    logic [N-1:0]  pend;
    logic [W-1:0]  pa[N];
    logic [W-1:0]  pb[N];
    int            waitc[N];
    int            mptr;
    int            g;
    int            guard;
    logic [W:0]    s;
    logic [W-1:0]  hold_y;

    initial begin
        // Grant order follows rr_ptr from 0 after reset; each row's ptr is derived from the row above.
        vecs[0] = '{4'b0100, 32'h0000_0005, 32'h0000_0007, 2, 32'h0000_000C, 1'b0};
        vecs[1] = '{4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1'b1};
        vecs[2] = '{4'b1111, 32'h8000_0000, 32'h8000_0000, 1, 32'h0000_0000, 1'b1};
        vecs[3] = '{4'b1001, 32'h1234_5678, 32'h0FED_CBA8, 3, 32'h2222_2220, 1'b0};
        vecs[4] = '{4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 1'b1};
        vecs[5] = '{4'b0010, 32'h0000_0000, 32'h0000_0000, 1, 32'h0000_0000, 1'b0};
        vecs[6] = '{4'b1000, 32'h7FFF_FFFF, 32'h0000_0001, 3, 32'h8000_0000, 1'b0};

        reset     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        #12;
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset rsp_y", 64'(rsp_y), 64'd0);
        chk("reset rsp_cout", 64'(rsp_cout), 64'd0);
        chk("reset rsp_id", 64'(rsp_id), 64'd0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        tick;

        for (int k = 0; k < 7; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

        // T1: reset while stalled in RESP; ptr would otherwise point at 3.
        for (int i = 0; i < N; i++) set_lane(i, 32'd1, 32'd2);
        req_valid = 4'b0100;
        tick;
        req_valid = '0;
        tick;
        tick;
        chk("t1 stalled rsp_valid", 64'(rsp_valid), 64'd1);
        req_valid = 4'b1111;
        #2;
        reset = 1'b1;
        #1;
        chk("t1 async rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t1 async busy", 64'(busy), 64'd0);
        chk("t1 async rsp_y", 64'(rsp_y), 64'd0);
        chk("t1 async req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t1 first grant", 64'(req_ready), 64'(onehot(0)));
        tick;
        req_valid = '0;
        tick;
        chk("t1 rsp_y", 64'(rsp_y), 64'd3);
        chk("t1 rsp_id", 64'(rsp_id), 64'd0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;

        // T4: all requesters hold valid; grants rotate 0..3 twice.
        pulse_reset();
        for (int i = 0; i < N; i++) begin
            pa[i] = 32'h1111_1111 * (i + 1);
            pb[i] = 32'hF000_0000 + i;
            set_lane(i, pa[i], pb[i]);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("t4 grant%0d", k), 64'(req_ready), 64'(onehot(k % N)));
            s = {1'b0, pa[k % N]} + {1'b0, pb[k % N]};
            tick;
            chk($sformatf("t4 exec ready%0d", k), 64'(req_ready), 64'd0);
            tick;
            chk($sformatf("t4 resp ready%0d", k), 64'(req_ready), 64'd0);
            chk($sformatf("t4 id%0d", k), 64'(rsp_id), 64'(k % N));
            chk($sformatf("t4 y%0d", k), 64'(rsp_y), 64'(s[W-1:0]));
            chk($sformatf("t4 cout%0d", k), 64'(rsp_cout), 64'(s[W]));
            rsp_ready = 1'b1;
            tick;
            rsp_ready = 1'b0;
        end
        req_valid = '0;

        // T5: ten cycles of back-pressure with other requesters waiting.
        set_lane(1, 32'hDEAD_BEEF, 32'h0000_1111);
        req_valid = 4'b0010;
        #1;
        chk("t5 grant", 64'(req_ready), 64'(onehot(1)));
        tick;
        req_valid = 4'b1111;
        tick;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("t5 valid c%0d", c), 64'(rsp_valid), 64'd1);
            chk($sformatf("t5 y c%0d", c), 64'(rsp_y), 64'h0000_0000_DEAD_D000);
            chk($sformatf("t5 id c%0d", c), 64'(rsp_id), 64'd1);
            chk($sformatf("t5 ready c%0d", c), 64'(req_ready), 64'd0);
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("t5 idle busy", 64'(busy), 64'd0);
        chk("t5 idle rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5 idle y held", 64'(rsp_y), 64'h0000_0000_DEAD_D000);
        chk("t5 new grant", 64'(req_ready), 64'(onehot(2)));
        tick;
        req_valid = '0;
        tick;
        chk("t5 second id", 64'(rsp_id), 64'd2);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;

        // T6: random operands, sticky random valids, random response stalls.
        pulse_reset();
        mptr = 0;
        pend = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int op = 0; op < 1000; op++) begin
            guard = 0;
            while (pend == '0 && guard < 100) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i] && $urandom_range(0, 1) == 1) begin
                        pend[i] = 1'b1;
                        pa[i]   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                        pb[i]   = 32'($urandom);
                        set_lane(i, pa[i], pb[i]);
                    end
                end
                if (pend == '0) begin
                    req_valid = '0;
                    #1;
                    chk("t6 idle no grant", 64'(req_ready), 64'd0);
                    tick;
                end
                guard++;
            end
            if (pend == '0) begin
                chk("t6 no request generated", 64'd0, 64'd1);
                pend[0] = 1'b1;
                pa[0]   = 32'd0;
                pb[0]   = 32'd0;
                set_lane(0, pa[0], pb[0]);
            end
            req_valid = pend;
            #1;
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
            end
            chk($sformatf("t6 grant op%0d", op), 64'(req_ready), 64'(onehot(g)));
            n_cmp++;
            if (waitc[g] > 3) begin
                n_bad++;
                $display("FAIL t6 starvation op%0d: req %0d waited %0d ops, required at most 3", op, g, waitc[g]);
            end
            for (int j = 0; j < N; j++) if (j != g && pend[j]) waitc[j]++;
            waitc[g] = 0;
            pend[g]  = 1'b0;
            mptr     = (g + 1) % N;
            s        = {1'b0, pa[g]} + {1'b0, pb[g]};
            tick;
            req_valid = pend;
            tick;
            chk($sformatf("t6 valid op%0d", op), 64'(rsp_valid), 64'd1);
            chk($sformatf("t6 y op%0d", op), 64'(rsp_y), 64'(s[W-1:0]));
            chk($sformatf("t6 cout op%0d", op), 64'(rsp_cout), 64'(s[W]));
            chk($sformatf("t6 id op%0d", op), 64'(rsp_id), 64'(g));
            hold_y = s[W-1:0];
            for (int c = 0; c < 30; c++) begin
                rsp_ready = ($urandom_range(0, 1) == 1) || (c >= 20);
                if (rsp_ready) break;
                tick;
                chk($sformatf("t6 stall op%0d", op), 64'({rsp_valid, req_ready, rsp_y}), 64'({1'b1, 4'b0000, hold_y}));
            end
            tick;
            rsp_ready = 1'b0;
            chk($sformatf("t6 done op%0d", op), 64'(busy), 64'd0);
        end
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
